mem_arbiter: RTL

//  Shares one single-port memory bus between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/LS memory arbiter: bus width, FSM states, winner encoding.
package mem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_LS = 2'd2,
    ARB_FAULT   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the shared memory bus: LS has priority unless IF has been
// passed over LS_MAX times in a row.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       if_req,
  input  logic       ls_req,
  input  logic       streak_full,
  output arb_owner_t winner
);

  always_comb begin
    winner = OWN_NONE;
    if (ls_req && !(if_req && streak_full)) begin
      winner = OWN_LS;
    end else if (if_req) begin
      winner = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and load/store, one
// outstanding transaction, response routed to its owner, sticky timeout fault.
//
// state        | meaning
// ARB_IDLE     | no transaction; winner drives mem_*, gnt follows mem_gnt
// ARB_WAIT_IF  | fetch accepted by memory, waiting for mem_rvalid
// ARB_WAIT_LS  | load/store accepted by memory, waiting for mem_rvalid
// ARB_FAULT    | response timed out; bus parked until rst_n
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LS_MAX  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [31:0]     if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy,
  output logic            fault
);

  localparam int SW = $clog2(LS_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LS_MAX);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  arb_state_t    state, state_next;
  logic [SW-1:0] streak, streak_next;
  logic [TW-1:0] tcnt, tcnt_next;
  logic          ls_store, ls_store_next;
  arb_owner_t    winner;

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .ls_req      (ls_req),
    .streak_full (streak == STREAK_MAX),
    .winner      (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      streak   <= '0;
      tcnt     <= '0;
      ls_store <= 1'b0;
    end else begin
      state    <= state_next;
      streak   <= streak_next;
      tcnt     <= tcnt_next;
      ls_store <= ls_store_next;
    end
  end

  always_comb begin
    state_next    = state;
    streak_next   = streak;
    tcnt_next     = tcnt;
    ls_store_next = ls_store;
    unique case (state)
      ARB_IDLE: begin
        if (mem_gnt && winner == OWN_LS) begin
          state_next    = ARB_WAIT_LS;
          tcnt_next     = '0;
          ls_store_next = ls_we;
          if (!if_req) begin
            streak_next = '0;
          end else if (streak != STREAK_MAX) begin
            streak_next = streak + SW'(1);
          end
        end else if (mem_gnt && winner == OWN_IF) begin
          state_next  = ARB_WAIT_IF;
          tcnt_next   = '0;
          streak_next = '0;
        end
      end
      ARB_WAIT_IF, ARB_WAIT_LS: begin
        tcnt_next = tcnt + TW'(1);
        if (mem_rvalid) begin
          state_next = ARB_IDLE;
        end else if (tcnt == TCNT_LAST) begin
          state_next = ARB_FAULT;
        end
      end
      ARB_FAULT: state_next = ARB_FAULT;
      default:   state_next = ARB_IDLE;
    endcase
  end

  // rdata is forced to zero outside its rvalid pulse so stale data never leaks.
  always_comb begin
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    ls_gnt    = 1'b0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != ARB_IDLE);
    fault     = (state == ARB_FAULT);
    unique case (state)
      ARB_IDLE: begin
        if (winner == OWN_LS) begin
          mem_req   = 1'b1;
          mem_we    = ls_we;
          mem_addr  = ls_addr;
          mem_wdata = ls_wdata;
          ls_gnt    = mem_gnt;
        end else if (winner == OWN_IF) begin
          mem_req  = 1'b1;
          mem_addr = if_addr;
          if_gnt   = mem_gnt;
        end
      end
      ARB_WAIT_IF: begin
        if (mem_rvalid) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata[31:0];
        end
      end
      ARB_WAIT_LS: begin
        if (mem_rvalid) begin
          ls_rvalid = 1'b1;
          ls_rdata  = ls_store ? '0 : mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
